// File: rtl/riscv_div_pkg.sv
// Shared definitions for the RISC-V divide issue path: opcode masks/matches,
// the issue-controller state encoding and the zero-divisor quotient value.
package riscv_div_pkg;

  localparam logic [31:0] DIV_MASK   = 32'hFE00707F;
  localparam logic [31:0] MATCH_DIV  = 32'h02004033;
  localparam logic [31:0] MATCH_DIVU = 32'h02005033;
  localparam logic [31:0] MATCH_REM  = 32'h02006033;
  localparam logic [31:0] MATCH_REMU = 32'h02007033;

  // Quotient returned for any x/0 (RISC-V defines it as all ones).
  localparam logic [31:0] BYPASS_QUOT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } div_state_e;

  // Architectural result of a divide by zero: all ones for a quotient,
  // the untouched dividend for a remainder.
  function automatic logic [31:0] zero_div_result(input logic        is_quotient,
                                                  input logic [31:0] dividend);
    return is_quotient ? BYPASS_QUOT : dividend;
  endfunction

endpackage

// File: rtl/riscv_div_decode.sv
// Combinational classifier for the M-extension divide/remainder opcodes.
// Shared between the issue controller and the divider itself.
module riscv_div_decode
  import riscv_div_pkg::*;
(
  input  logic [31:0] opcode_i,
  output logic        is_div_rem_o,
  output logic        is_signed_o,
  output logic        is_quotient_o
);

  logic [31:0] w_masked;

  assign w_masked = opcode_i & DIV_MASK;

  // Match the masked word against the four divide encodings.
  always_comb begin
    is_div_rem_o  = 1'b0;
    is_signed_o   = 1'b0;
    is_quotient_o = 1'b0;
    case (w_masked)
      MATCH_DIV: begin
        is_div_rem_o  = 1'b1;
        is_signed_o   = 1'b1;
        is_quotient_o = 1'b1;
      end
      MATCH_DIVU: begin
        is_div_rem_o  = 1'b1;
        is_quotient_o = 1'b1;
      end
      MATCH_REM: begin
        is_div_rem_o  = 1'b1;
        is_signed_o   = 1'b1;
      end
      MATCH_REMU: begin
        is_div_rem_o  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_div_issue_ctrl.sv
// Issue controller between execute and the iterative 32-bit divider:
// accepts divide/remainder ops, holds operands, stalls the pipe while the
// divider runs, short-circuits x/0, drops flushed results and times out
// a divider that never answers.
module riscv_div_issue_ctrl
  import riscv_div_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 48
)(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  input  logic [31:0] req_opcode_i,
  input  logic [31:0] req_rs1_i,
  input  logic [31:0] req_rs2_i,
  input  logic [4:0]  req_rd_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        div_valid_o,
  output logic [31:0] div_opcode_o,
  output logic [31:0] div_dividend_o,
  output logic [31:0] div_divisor_o,
  input  logic        div_busy_i,
  input  logic        div_valid_i,
  input  logic [31:0] div_result_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_value_o,
  output logic        wb_err_o,
  output logic        timeout_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  div_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stall;
  logic             r_div_valid;
  logic [31:0]      r_opcode;
  logic [31:0]      r_dividend;
  logic [31:0]      r_divisor;
  logic [4:0]       r_rd;
  logic             r_wb_valid;
  logic [4:0]       r_wb_rd;
  logic [31:0]      r_wb_value;
  logic             r_wb_err;
  logic             r_timeout;

  logic             w_is_div_rem;
  logic             w_is_signed;
  logic             w_is_quotient;
  logic             w_accept;
  logic             w_bypass;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_cnt_done;
  logic             w_unused;

  riscv_div_decode u_decode (
    .opcode_i      (req_opcode_i),
    .is_div_rem_o  (w_is_div_rem),
    .is_signed_o   (w_is_signed),
    .is_quotient_o (w_is_quotient)
  );

  // Busy is informational only and signedness matters to the divider, not here.
  assign w_unused = ^{div_busy_i, w_is_signed};

  assign w_accept   = (r_state == ST_IDLE) && req_valid_i && w_is_div_rem && !flush_i;
  assign w_bypass   = (req_rs2_i == 32'd0);
  // r_cnt holds the number of cycles elapsed since the ISSUE cycle.
  assign w_cnt_inc  = r_cnt + CNT_W'(1);
  assign w_cnt_done = (w_cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Issue FSM with all outputs registered; pulses default low every cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_stall     <= 1'b0;
      r_div_valid <= 1'b0;
      r_opcode    <= '0;
      r_dividend  <= '0;
      r_divisor   <= '0;
      r_rd        <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_rd     <= '0;
      r_wb_value  <= '0;
      r_wb_err    <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_div_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_timeout   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_cnt <= '0;
          if (w_accept) begin
            r_opcode   <= req_opcode_i;
            r_dividend <= req_rs1_i;
            r_divisor  <= req_rs2_i;
            r_rd       <= req_rd_i;
            if (w_bypass) begin
              // x/0 has a fixed answer; the divider is never engaged.
              r_wb_valid <= 1'b1;
              r_wb_rd    <= req_rd_i;
              r_wb_value <= zero_div_result(w_is_quotient, req_rs1_i);
              r_wb_err   <= 1'b0;
            end else begin
              r_state     <= ST_ISSUE;
              r_div_valid <= 1'b1;
              r_stall     <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          r_cnt   <= w_cnt_inc;
          r_state <= flush_i ? ST_DRAIN : ST_WAIT;
        end
        ST_WAIT: begin
          if (div_valid_i) begin
            // A flush in the same cycle as the response simply drops it.
            r_state <= ST_IDLE;
            r_stall <= 1'b0;
            if (!flush_i) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_value <= div_result_i;
              r_wb_err   <= 1'b0;
            end
          end else if (w_cnt_done) begin
            r_state   <= ST_IDLE;
            r_stall   <= 1'b0;
            r_timeout <= 1'b1;
            if (!flush_i) begin
              r_wb_valid <= 1'b1;
              r_wb_rd    <= r_rd;
              r_wb_value <= '0;
              r_wb_err   <= 1'b1;
            end
          end else begin
            r_cnt <= w_cnt_inc;
            if (flush_i) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          // The divider cannot be aborted, so wait out its answer and drop it.
          if (div_valid_i) begin
            r_state <= ST_IDLE;
            r_stall <= 1'b0;
          end else if (w_cnt_done) begin
            r_state   <= ST_IDLE;
            r_stall   <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign stall_o        = r_stall;
  assign div_valid_o    = r_div_valid;
  assign div_opcode_o   = r_opcode;
  assign div_dividend_o = r_dividend;
  assign div_divisor_o  = r_divisor;
  assign wb_valid_o     = r_wb_valid;
  assign wb_rd_o        = r_wb_rd;
  assign wb_value_o     = r_wb_value;
  assign wb_err_o       = r_wb_err;
  assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_riscv_div_issue_ctrl.sv
// Bench for riscv_div_issue_ctrl: directed scenarios plus randomized
// transactions, each checked against transaction-level timing expectations
// and a behavioural RISC-V divide model.
module tb_riscv_div_issue_ctrl;

  localparam logic [31:0] MASK    = 32'hFE00707F;
  localparam logic [31:0] OP_DIV  = 32'h02004033;
  localparam logic [31:0] OP_DIVU = 32'h02005033;
  localparam logic [31:0] OP_REM  = 32'h02006033;
  localparam logic [31:0] OP_REMU = 32'h02007033;
  localparam int          TMO     = 48;
  localparam int          DIV_LAT = 35;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic [31:0] req_opcode_i;
  logic [31:0] req_rs1_i;
  logic [31:0] req_rs2_i;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic        stall_o;
  logic        div_valid_o;
  logic [31:0] div_opcode_o;
  logic [31:0] div_dividend_o;
  logic [31:0] div_divisor_o;
  logic        div_busy_i;
  logic        div_valid_i;
  logic [31:0] div_result_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic        wb_err_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_fail   = 0;

  riscv_div_issue_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_opcode_i   (req_opcode_i),
    .req_rs1_i      (req_rs1_i),
    .req_rs2_i      (req_rs2_i),
    .req_rd_i       (req_rd_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .div_valid_o    (div_valid_o),
    .div_opcode_o   (div_opcode_o),
    .div_dividend_o (div_dividend_o),
    .div_divisor_o  (div_divisor_o),
    .div_busy_i     (div_busy_i),
    .div_valid_i    (div_valid_i),
    .div_result_i   (div_result_i),
    .wb_valid_o     (wb_valid_o),
    .wb_rd_o        (wb_rd_o),
    .wb_value_o     (wb_value_o),
    .wb_err_o       (wb_err_o),
    .timeout_o      (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic bit is_divop(input logic [31:0] op);
    logic [31:0] m;
    m = op & MASK;
    return (m == OP_DIV) || (m == OP_DIVU) || (m == OP_REM) || (m == OP_REMU);
  endfunction

  // Behavioural RISC-V M-extension divide/remainder, including x/0 and overflow.
  function automatic logic [31:0] ref_result(input logic [31:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [31:0]        m;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    bit                 ovf;
    m   = op & MASK;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    if (b == 32'd0) return ((m == OP_DIV) || (m == OP_DIVU)) ? 32'hFFFFFFFF : a;
    if (m == OP_DIV)  return ovf ? 32'h80000000 : 32'(sa / sb);
    if (m == OP_DIVU) return a / b;
    if (m == OP_REM)  return ovf ? 32'd0 : 32'(sa % sb);
    return a % b;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h80000000;
      1:       return 32'hFFFFFFFF;
      2:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic idle_req();
    req_valid_i  = 1'b0;
    req_opcode_i = $urandom;
    req_rs1_i    = $urandom;
    req_rs2_i    = $urandom;
    req_rd_i     = 5'($urandom);
  endtask

  // One instruction presented in the current cycle (cycle 0). Returns positioned
  // in the cycle where the next request may be presented. flush_at < 0 means no
  // flush; respond=0 models a divider that never answers.
  task automatic run_txn(input logic [31:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] rd, input int flush_at, input bit respond,
                         input bit drain_req);
    logic [31:0] m;
    logic [31:0] exp_val;
    logic [31:0] s_op;
    logic [31:0] s_a;
    logic [31:0] s_b;
    int          fin;
    bit          wb_exp;
    m = op & MASK;
    req_valid_i  = 1'b1;
    req_opcode_i = op;
    req_rs1_i    = rs1;
    req_rs2_i    = rs2;
    req_rd_i     = rd;
    step();
    idle_req();
    if (!is_divop(op)) begin
      check_eq("nodiv_wb_valid", 32'(wb_valid_o), 32'd0);
      check_eq("nodiv_stall", 32'(stall_o), 32'd0);
      check_eq("nodiv_issue", 32'(div_valid_o), 32'd0);
      return;
    end
    if (rs2 == 32'd0) begin
      exp_val = ((m == OP_DIV) || (m == OP_DIVU)) ? 32'hFFFFFFFF : rs1;
      check_eq("byp_wb_valid", 32'(wb_valid_o), 32'd1);
      check_eq("byp_wb_rd", 32'(wb_rd_o), 32'(rd));
      check_eq("byp_wb_value", wb_value_o, exp_val);
      check_eq("byp_wb_err", 32'(wb_err_o), 32'd0);
      check_eq("byp_stall", 32'(stall_o), 32'd0);
      check_eq("byp_issue", 32'(div_valid_o), 32'd0);
      return;
    end
    fin    = respond ? DIV_LAT + 2 : TMO + 1;
    wb_exp = (flush_at < 0);
    s_op   = '0;
    s_a    = '0;
    s_b    = '0;
    for (int c = 1; c <= fin; c++) begin
      check_eq($sformatf("issue_c%0d", c), 32'(div_valid_o), 32'(c == 1));
      check_eq($sformatf("stall_c%0d", c), 32'(stall_o), 32'(c < fin));
      check_eq($sformatf("wb_valid_c%0d", c), 32'(wb_valid_o), 32'((c == fin) && wb_exp));
      check_eq($sformatf("timeout_c%0d", c), 32'(timeout_o), 32'((c == fin) && !respond));
      if (c == 2) begin
        s_op = div_opcode_o;
        s_a  = div_dividend_o;
        s_b  = div_divisor_o;
      end
      if ((c == 2) || (c == fin)) begin
        check_eq("held_opcode", div_opcode_o, op);
        check_eq("held_dividend", div_dividend_o, rs1);
        check_eq("held_divisor", div_divisor_o, rs2);
      end
      if ((c == fin) && wb_exp) begin
        check_eq("wb_rd", 32'(wb_rd_o), 32'(rd));
        check_eq("wb_value", wb_value_o, respond ? ref_result(op, rs1, rs2) : 32'd0);
        check_eq("wb_err", 32'(wb_err_o), 32'(!respond));
      end
      if (c < fin) begin
        flush_i      = (c == flush_at);
        div_busy_i   = (c >= 2) && (c <= DIV_LAT + 1);
        div_valid_i  = respond && (c == DIV_LAT + 1);
        div_result_i = div_valid_i ? ref_result(s_op, s_a, s_b) : $urandom;
        if (drain_req && (flush_at >= 0) && (c == flush_at + 3)) begin
          req_valid_i  = 1'b1;
          req_opcode_i = OP_DIV;
          req_rs1_i    = $urandom;
          req_rs2_i    = 32'($urandom_range(1, 1000)) ^ rs2 ^ 32'h0000_1000;
          req_rd_i     = 5'($urandom);
        end
        step();
        idle_req();
        flush_i     = 1'b0;
        div_valid_i = 1'b0;
        div_busy_i  = 1'b0;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    rst_i        = 1'b1;
    flush_i      = 1'b0;
    div_busy_i   = 1'b0;
    div_valid_i  = 1'b0;
    div_result_i = '0;
    idle_req();
    step();
    step();
    check_eq("rst_stall", 32'(stall_o), 32'd0);
    check_eq("rst_div_valid", 32'(div_valid_o), 32'd0);
    check_eq("rst_div_opcode", div_opcode_o, 32'd0);
    check_eq("rst_div_dividend", div_dividend_o, 32'd0);
    check_eq("rst_div_divisor", div_divisor_o, 32'd0);
    check_eq("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check_eq("rst_wb_rd", 32'(wb_rd_o), 32'd0);
    check_eq("rst_wb_value", wb_value_o, 32'd0);
    check_eq("rst_wb_err", 32'(wb_err_o), 32'd0);
    check_eq("rst_timeout", 32'(timeout_o), 32'd0);
    rst_i = 1'b0;
    step();

    // -7 / 2 signed, then REMU 100 % 7 twice with no gap.
    run_txn(OP_DIV | 32'h00208280, 32'hFFFFFFF9, 32'd2, 5'd5, -1, 1'b1, 1'b0);
    run_txn(OP_REMU, 32'd100, 32'd7, 5'd9, -1, 1'b1, 1'b0);
    run_txn(OP_REMU, 32'd100, 32'd7, 5'd10, -1, 1'b1, 1'b0);

    // Divide by zero short-circuits.
    run_txn(OP_DIVU, 32'h12345678, 32'd0, 5'd3, -1, 1'b1, 1'b0);
    check_eq("byp_nostall_next", 32'(stall_o), 32'd0);
    run_txn(OP_REM, 32'hFFFFFFFB, 32'd0, 5'd4, -1, 1'b1, 1'b0);
    step();
    check_eq("byp_wb_pulse", 32'(wb_valid_o), 32'd0);

    // Flush mid-wait, with a blocked request during drain.
    run_txn(OP_DIV, 32'd1000, 32'd3, 5'd6, 10, 1'b1, 1'b1);
    step();
    check_eq("flush_no_late_wb", 32'(wb_valid_o), 32'd0);

    // Divider never answers, then a normal op recovers.
    run_txn(OP_DIVU, 32'd77, 32'd5, 5'd11, -1, 1'b0, 1'b0);
    run_txn(OP_REM, 32'hFFFFFFF0, 32'd3, 5'd12, -1, 1'b1, 1'b0);

    // Reset in the middle of a wait; the late response must be ignored.
    req_valid_i  = 1'b1;
    req_opcode_i = OP_DIV;
    req_rs1_i    = 32'd500;
    req_rs2_i    = 32'd3;
    req_rd_i     = 5'd7;
    step();
    idle_req();
    for (int c = 1; c <= DIV_LAT + 2; c++) begin
      if (c == 20) check_eq("prerst_stall", 32'(stall_o), 32'd1);
      if (c == 21) begin
        check_eq("mrst_stall", 32'(stall_o), 32'd0);
        check_eq("mrst_div_valid", 32'(div_valid_o), 32'd0);
        check_eq("mrst_div_opcode", div_opcode_o, 32'd0);
        check_eq("mrst_div_dividend", div_dividend_o, 32'd0);
        check_eq("mrst_div_divisor", div_divisor_o, 32'd0);
        check_eq("mrst_wb_valid", 32'(wb_valid_o), 32'd0);
        check_eq("mrst_wb_rd", 32'(wb_rd_o), 32'd0);
        check_eq("mrst_wb_value", wb_value_o, 32'd0);
        check_eq("mrst_wb_err", 32'(wb_err_o), 32'd0);
        check_eq("mrst_timeout", 32'(timeout_o), 32'd0);
      end
      if (c > 21) begin
        check_eq($sformatf("postrst_wb_c%0d", c), 32'(wb_valid_o), 32'd0);
        check_eq($sformatf("postrst_stall_c%0d", c), 32'(stall_o), 32'd0);
      end
      if (c < DIV_LAT + 2) begin
        rst_i        = (c == 20);
        div_valid_i  = (c == DIV_LAT + 1);
        div_result_i = 32'h12345678;
        step();
      end
    end
    rst_i       = 1'b0;
    div_valid_i = 1'b0;

    // Randomized transactions.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] op;
      logic [31:0] a;
      logic [31:0] b;
      int          fl;
      bit          rsp;
      case ($urandom_range(0, 4))
        0:       op = OP_DIV  | ($urandom & ~MASK);
        1:       op = OP_DIVU | ($urandom & ~MASK);
        2:       op = OP_REM  | ($urandom & ~MASK);
        3:       op = OP_REMU | ($urandom & ~MASK);
        default: op = $urandom;
      endcase
      a   = pick_operand();
      b   = ($urandom_range(0, 3) == 0) ? 32'd0 : pick_operand();
      fl  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 36)) : -1;
      rsp = ($urandom_range(0, 7) != 0);
      run_txn(op, a, b, 5'($urandom), fl, rsp, 1'b1);
      repeat ($urandom_range(0, 2)) step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
